// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter for VGA scanout, host writes and fill.
// Optional fill engine is built when VGA_FB_ARB_FILL_EN is defined.
module vga_fb_arbiter #(
  parameter int PIXEL_W     = 12,
  parameter int H_BITS      = 10,
  parameter int V_BITS      = 10,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = $clog2(FB_W*FB_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic               vga_active,
  input  logic [H_BITS-1:0]  vga_x,
  input  logic [V_BITS-1:0]  vga_y,
  output logic               pix_valid,
  output logic [PIXEL_W-1:0] pix_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               fill_start,
  input  logic [PIXEL_W-1:0] fill_color,
  output logic               fill_busy,
  output logic               fill_done,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_re,
  output logic               ram_we,
  output logic [PIXEL_W-1:0] ram_wdata,
  input  logic [PIXEL_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FB_W*FB_H-1);
  localparam logic [H_BITS-1:0] MAX_X = H_BITS'(FB_W);
  localparam logic [V_BITS-1:0] MAX_Y = V_BITS'(FB_H);

  logic [H_BITS-1:0]  fb_x;
  logic [V_BITS-1:0]  fb_y;
  logic               disp_req;
  logic [ADDR_W-1:0]  disp_addr;
  logic               host_we;
  logic               fill_we;
  logic [ADDR_W-1:0]  fill_addr;
  logic [PIXEL_W-1:0] fill_wdata;
  logic               tick1, tick2, req2;

  assign fb_x      = vga_x >> SCALE_SHIFT;
  assign fb_y      = vga_y >> SCALE_SHIFT;
  assign disp_req  = pix_en && vga_active && (fb_x < MAX_X) && (fb_y < MAX_Y);
  assign disp_addr = ADDR_W'(fb_y) * ADDR_W'(FB_W) + ADDR_W'(fb_x);

  // Host only gets cycles the display and fill engine leave free.
  assign wr_ready = !rst && !disp_req && !fill_busy;
  assign host_we  = wr_valid && wr_ready && (wr_addr <= LAST);

`ifdef VGA_FB_ARB_FILL_EN
  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [PIXEL_W-1:0] color_q, color_d;
  logic               done_d;

  assign fill_busy  = (state_q == FILL);
  assign fill_addr  = ptr_q;
  assign fill_wdata = color_q;

  // Fill sequencing: walk every address, yielding to display ticks.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    color_d = color_q;
    done_d  = 1'b0;
    fill_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          color_d = fill_color;
          ptr_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!disp_req) begin
          fill_we = 1'b1;
          if (ptr_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Fill state registers; reset aborts any fill in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      color_q   <= '0;
      fill_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      color_q   <= color_d;
      fill_done <= done_d;
    end
  end
`else
  logic unused_fill;

  assign unused_fill = fill_start ^ (^fill_color);
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
  assign fill_we     = 1'b0;
  assign fill_addr   = '0;
  assign fill_wdata  = '0;
`endif

  // Registered RAM command: display read, else fill write, else host write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_re <= disp_req;
      ram_we <= !disp_req && (fill_we || host_we);
      if (disp_req) begin
        ram_addr <= disp_addr;
      end else if (fill_we) begin
        ram_addr  <= fill_addr;
        ram_wdata <= fill_wdata;
      end else if (host_we) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end
    end
  end

  // Pixel pipeline: every tick returns a pixel three cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick1     <= 1'b0;
      tick2     <= 1'b0;
      req2      <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      tick1     <= pix_en;
      tick2     <= tick1;
      req2      <= ram_re;
      pix_valid <= tick2;
      pix_data  <= req2 ? ram_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for vga_fb_arbiter with a behavioural RAM.
// Fill scenarios are exercised when VGA_FB_ARB_FILL_EN is defined.
module tb_vga_fb_arbiter;

  logic        clk, rst;
  logic        pix_en, vga_active;
  logic [9:0]  vga_x, vga_y;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        wr_valid, wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        fill_start;
  logic [11:0] fill_color;
  logic        fill_busy, fill_done;
  logic [14:0] ram_addr;
  logic        ram_re, ram_we;
  logic [11:0] ram_wdata, ram_rdata;

  typedef struct {
    int          cyc;
    logic        we;
    logic [14:0] addr;
    logic [11:0] data;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic [11:0] data;
  } pix_t;

  cmd_t cq[$];
  pix_t pq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [11:0] mem [0:19199];

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst),
    .pix_en(pix_en), .vga_active(vga_active),
    .vga_x(vga_x), .vga_y(vga_y),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_addr(ram_addr), .ram_re(ram_re),
    .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = '0;
    ram_rdata = '0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic push_read(int c, logic [14:0] a);
    cq.push_back('{c, 1'b0, a, 12'h000});
  endtask

  task automatic push_write(int c, logic [14:0] a, logic [11:0] d);
    cq.push_back('{c, 1'b1, a, d});
  endtask

  task automatic push_pix(int c, logic [11:0] d);
    pq.push_back('{c, d});
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    pix_t p;
    cmd_t c;
    #2;
    if (!rst) begin
      if (pix_valid) begin
        if (pq.size() == 0) begin
          chk("pix_unexpected", {32'(cyc), 20'd0, pix_data}, 64'd0);
        end else begin
          p = pq.pop_front();
          chk("pix", {32'(cyc), 20'd0, pix_data},
              {32'(p.cyc), 20'd0, p.data});
        end
      end
      if (ram_re || ram_we) begin
        if (cq.size() == 0) begin
          chk("cmd_unexpected",
              {32'(cyc), 3'd0, ram_re, ram_we, ram_addr, ram_wdata}, 64'd0);
        end else begin
          c = cq.pop_front();
          chk("ram_cmd",
              {32'(cyc), 3'd0, ram_re, ram_we, ram_addr,
               ram_we ? ram_wdata : 12'h000},
              {32'(c.cyc), 3'd0, !c.we, c.we, c.addr, c.data});
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(logic act, logic [9:0] x, logic [9:0] y,
                         bit inr, logic [14:0] a, logic [11:0] d);
    pix_en     = 1'b1;
    vga_active = act;
    vga_x      = x;
    vga_y      = y;
    if (inr) push_read(cyc + 1, a);
    push_pix(cyc + 3, d);
    next_cycle();
    pix_en = 1'b0;
  endtask

  task automatic do_write(logic [14:0] a, logic [11:0] d, bit inr);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    chk("wr_ready", 64'(wr_ready), 64'd1);
    if (inr) push_write(cyc + 1, a, d);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  initial begin
    int s, busy, dn, dc, rdy_bad;
    rst = 1'b1; pix_en = 1'b0; vga_active = 1'b0;
    vga_x = '0; vga_y = '0;
    wr_valid = 1'b1; wr_addr = '0; wr_data = '0;
    fill_start = 1'b0; fill_color = '0;
    next_cycle();
    @(negedge clk);
    chk("reset_outputs",
        {pix_valid, pix_data, ram_re, ram_we, ram_addr, ram_wdata,
         fill_busy, fill_done}, 64'd0);
    chk("reset_wr_ready", 64'(wr_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_write(15'd161, 12'hABC, 1);
    do_tick(1'b1, 10'd4, 10'd4, 1, 15'd161, 12'hABC);
    do_tick(1'b1, 10'd7, 10'd7, 1, 15'd161, 12'hABC);

    // Collision then read-after-write
    pix_en = 1'b1; vga_active = 1'b1; vga_x = 10'd8; vga_y = 10'd4;
    wr_valid = 1'b1; wr_addr = 15'd162; wr_data = 12'h5A5;
    push_read(cyc + 1, 15'd162);
    push_pix(cyc + 3, 12'h000);
    @(negedge clk);
    chk("collision_wr_ready", 64'(wr_ready), 64'd0);
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    @(negedge clk);
    chk("collision_retry_ready", 64'(wr_ready), 64'd1);
    push_write(cyc + 1, 15'd162, 12'h5A5);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    do_tick(1'b1, 10'd8, 10'd4, 1, 15'd162, 12'h5A5);

    // Boundaries
    do_tick(1'b1, 10'd640, 10'd0, 0, 15'd0, 12'h000);
    do_tick(1'b1, 10'd0, 10'd480, 0, 15'd0, 12'h000);
    do_tick(1'b0, 10'd4, 10'd4, 0, 15'd0, 12'h000);
    do_write(15'd19199, 12'h777, 1);
    do_tick(1'b1, 10'd639, 10'd479, 1, 15'd19199, 12'h777);
    do_write(15'd19200, 12'hBAD, 0);
    do_write(15'd32767, 12'hBAD, 0);

    // Back-to-back ticks
    do_write(15'd0, 12'h111, 1);
    do_write(15'd1, 12'h222, 1);
    do_write(15'd2, 12'h333, 1);
    do_tick(1'b1, 10'd0, 10'd0, 1, 15'd0, 12'h111);
    do_tick(1'b1, 10'd4, 10'd0, 1, 15'd1, 12'h222);
    do_tick(1'b1, 10'd11, 10'd3, 1, 15'd2, 12'h333);
    do_tick(1'b1, 10'd3, 10'd0, 1, 15'd0, 12'h111);
    repeat (4) next_cycle();

    // Reset mid-stream
    do_tick(1'b1, 10'd4, 10'd4, 1, 15'd161, 12'hABC);
    #2;
    chk("pre_reset_ram_re", 64'(ram_re), 64'd1);
    rst = 1'b1;
    #1;
    chk("midreset_outputs",
        {pix_valid, pix_data, ram_re, ram_we, ram_addr, ram_wdata,
         fill_busy, fill_done}, 64'd0);
    chk("midreset_wr_ready", 64'(wr_ready), 64'd0);
    pq.delete();
    cq.delete();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    repeat (4) next_cycle();

`ifdef VGA_FB_ARB_FILL_EN
    // Full fill with host stalled and a stray restart request
    s = cyc;
    fill_start = 1'b1; fill_color = 12'h0F0;
    for (int i = 0; i < 19200; i++) push_write(s + 2 + i, 15'(i), 12'h0F0);
    next_cycle();
    fill_start = 1'b0;
    busy = 0; dn = 0; dc = -1; rdy_bad = 0;
    for (int k = 1; k <= 19205; k++) begin
      wr_valid = (k <= 19201); wr_addr = 15'd5; wr_data = 12'hEEE;
      fill_start = (k == 50);
      fill_color = (k == 50) ? 12'hF00 : 12'h0F0;
      @(negedge clk);
      if (fill_busy) busy++;
      if (fill_busy && wr_ready) rdy_bad++;
      if (fill_done) begin dn++; dc = cyc; end
      if (k == 19201) begin
        chk("wr_ready_after_fill", 64'(wr_ready), 64'd1);
        push_write(cyc + 1, 15'd5, 12'hEEE);
      end
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0; fill_start = 1'b0;
    chk("fill_busy_cycles", 64'(busy), 64'd19200);
    chk("fill_wr_ready_low", 64'(rdy_bad), 64'd0);
    chk("fill_done_count", 64'(dn), 64'd1);
    chk("fill_done_cycle", 64'(dc), 64'(s + 19201));

    // Fill sharing with display ticks every other cycle
    s = cyc;
    fill_start = 1'b1; fill_color = 12'h00F;
    for (int j = 0; j < 19200; j++) begin
      push_read(s + 2 + 2*j, 15'd0);
      push_write(s + 3 + 2*j, 15'(j), 12'h00F);
      push_pix(s + 4 + 2*j, (j == 0) ? 12'h0F0 : 12'h00F);
    end
    next_cycle();
    fill_start = 1'b0;
    busy = 0; dn = 0; dc = -1;
    vga_active = 1'b1; vga_x = '0; vga_y = '0;
    for (int k = 1; k <= 38405; k++) begin
      pix_en = (k % 2 == 1) && (k < 38400);
      @(negedge clk);
      if (fill_busy) busy++;
      if (fill_done) begin dn++; dc = cyc; end
      @(posedge clk);
      #1;
    end
    pix_en = 1'b0;
    chk("shared_fill_busy_cycles", 64'(busy), 64'd38400);
    chk("shared_fill_done_count", 64'(dn), 64'd1);
    chk("shared_fill_done_cycle", 64'(dc), 64'(s + 38401));

    // Abort after 100 writes, then restart from address 0
    s = cyc;
    fill_start = 1'b1; fill_color = 12'h333;
    for (int i = 0; i < 100; i++) push_write(s + 2 + i, 15'(i), 12'h333);
    next_cycle();
    fill_start = 1'b0;
    repeat (101) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_fill_busy", 64'(fill_busy), 64'd0);
    chk("abort_fill_done", 64'(fill_done), 64'd0);
    chk("abort_writes_seen", 64'(cq.size()), 64'd0);
    cq.delete();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    dn = 0; busy = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (fill_done) dn++;
      if (fill_busy) busy++;
      @(posedge clk);
      #1;
    end
    chk("post_abort_idle", 64'(busy + dn), 64'd0);
    s = cyc;
    fill_start = 1'b1; fill_color = 12'h444;
    for (int i = 0; i < 5; i++) push_write(s + 2 + i, 15'(i), 12'h444);
    next_cycle();
    fill_start = 1'b0;
    repeat (5) next_cycle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("restart_writes_seen", 64'(cq.size()), 64'd0);
    cq.delete();
    next_cycle();
    rst = 1'b0;
    repeat (2) next_cycle();
`else
    // Fill request must be inert without the fill engine
    fill_start = 1'b1; fill_color = 12'h0F0;
    do_write(15'd10, 12'h0AA, 1);
    fill_start = 1'b0;
    busy = 0; dn = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (fill_busy) busy++;
      if (fill_done) dn++;
      @(posedge clk);
      #1;
    end
    chk("nofill_busy", 64'(busy), 64'd0);
    chk("nofill_done", 64'(dn), 64'd0);
    do_tick(1'b1, 10'd40, 10'd0, 1, 15'd10, 12'h0AA);
    rdy_bad = 0;
`endif

    repeat (6) next_cycle();
    chk("pix_queue_drained", 64'(pq.size()), 64'd0);
    chk("cmd_queue_drained", 64'(cq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
